cache_sa: RTL and testbench

- Parametrised set-associative, write-through, no-write-allocate data cache. It replaces the fixed direct-mapped cache between the CPU datapath (ALU address, rs2 write data) and datamem.
- Read hits return data combinationally, with no stall, so single-cycle operation is preserved.
- Misses and all writes stall the core while a word-serial handshake with backing memory runs.
- Adds hit/miss counters and a flush.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way.sv | 49 ++++
 rtl/cache_sa.sv | 169 ++++++++++++++++
 tb/tb_cache_sa.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, width helpers and constants for the set-associative cache
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic int off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int sets, input int block_words);
    return addr_width - $clog2(sets) - $clog2(block_words) - 2;
  endfunction

  // Refill counter needs at least one bit even for single-word lines.
  function automatic int cnt_w(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 1;
  endfunction
endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one cache way: valid/tag/data arrays, combinational compare, byte-enabled word write
module cache_way #(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 25,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [CNT_W-1:0] i_rd_off,
  output logic             o_hit,
  output logic [31:0]      o_rdata,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_wr_off,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wbe,
  input  logic             i_set_valid,
  input  logic             i_clr_valid
);
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS][BLOCK_WORDS];

  assign o_hit   = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_rdata = r_data[i_index][i_rd_off];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= '0;
    end else begin
      if (i_clr_valid) r_valid[i_index] <= 1'b0;
      if (i_set_valid) r_valid[i_index] <= 1'b1;
    end
  end

  // Tag and data storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[b]) r_data[i_index][i_wr_off][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_set_valid) r_tag[i_index] <= i_tag;
  end
endmodule

// File: rtl/cache_sa.sv
// rtl/cache_sa.sv - set-associative write-through no-write-allocate data cache with stall handshake
module cache_sa import cache_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OFF   = off_w(BLOCK_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS, BLOCK_WORDS);
  localparam int CNT_W = cnt_w(BLOCK_WORDS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t           r_state, w_state_nxt;
  logic [WAY_W-1:0] r_victim;
  logic [WAY_W-1:0] r_rr [SETS];
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr_done;
  logic [31:0]      r_hit_count, r_miss_count;

  logic [IDX_W-1:0]      w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [CNT_W-1:0]      w_off, w_wr_off;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic [WAYS-1:0]       w_hit_vec;
  logic [31:0]           w_rd [WAYS];
  logic [31:0]           w_rword, w_wdata, w_hit_cnt_nxt, w_miss_cnt_nxt;
  logic [3:0]            w_wbe;
  logic w_idle, w_hit, w_active, w_load_hit, w_load_miss, w_store_go;
  logic w_refill_ack, w_write_ack, w_last, w_flush_now;

  assign w_index     = IDX_W'(req_addr >> (OFF + 2));
  assign w_tag       = TAG_W'(req_addr >> (OFF + 2 + IDX_W));
  assign w_off       = CNT_W'((req_addr >> 2) & ADDR_WIDTH'(BLOCK_WORDS - 1));
  assign w_line_base = req_addr & ~(ADDR_WIDTH'(BLOCK_WORDS * 4 - 1));

  assign w_idle       = (r_state == IDLE);
  assign w_flush_now  = w_idle && flush;
  assign w_hit        = |w_hit_vec;
  assign w_active     = w_idle && req_valid && !flush;
  assign w_load_hit   = w_active && !req_write && w_hit;
  assign w_load_miss  = w_active && !req_write && !w_hit;
  // The retried store after its ack is retired without a second memory write.
  assign w_store_go   = w_active && req_write && !r_wr_done;
  assign w_refill_ack = (r_state == REFILL) && mem_ack;
  assign w_write_ack  = (r_state == WRITE) && mem_ack;
  assign w_last       = (r_cnt == CNT_W'(BLOCK_WORDS - 1));

  assign w_wr_off = (r_state == REFILL) ? r_cnt : w_off;
  assign w_wdata  = (r_state == REFILL) ? mem_rdata : req_wdata;
  assign w_wbe    = (r_state == REFILL) ? BE_ALL : req_be;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_flush_now),
      .i_index     (w_index),
      .i_tag       (w_tag),
      .i_rd_off    (w_off),
      .o_hit       (w_hit_vec[w]),
      .o_rdata     (w_rd[w]),
      .i_we        ((w_refill_ack && r_victim == WAY_W'(w)) || (w_write_ack && w_hit_vec[w])),
      .i_wr_off    (w_wr_off),
      .i_wdata     (w_wdata),
      .i_wbe       (w_wbe),
      .i_set_valid (w_refill_ack && w_last && r_victim == WAY_W'(w)),
      .i_clr_valid (w_load_miss && r_rr[w_index] == WAY_W'(w))
    );
  end

  always_comb begin
    w_rword = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit_vec[w]) w_rword = w_rword | w_rd[w];
    end
  end

  assign rdata      = w_load_hit ? w_rword : '0;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign w_hit_cnt_nxt  = (w_load_hit && r_hit_count != '1) ? r_hit_count + 32'd1 : r_hit_count;
  assign w_miss_cnt_nxt = (w_load_miss && r_miss_count != '1) ? r_miss_count + 32'd1 : r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    case (r_state)
      IDLE: begin
        stall = (req_valid && flush) || w_load_miss || w_store_go;
        if (w_load_miss)     w_state_nxt = REFILL;
        else if (w_store_go) w_state_nxt = WRITE;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_line_base | (ADDR_WIDTH'(r_cnt) << 2);
        if (mem_ack && w_last) w_state_nxt = IDLE;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = req_wdata;
        mem_be    = req_be;
        if (mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_victim     <= '0;
      r_wr_done    <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_hit_count  <= w_hit_cnt_nxt;
      r_miss_count <= w_miss_cnt_nxt;
      if (w_load_miss) begin
        r_victim <= r_rr[w_index];
        r_cnt    <= '0;
      end
      if (w_refill_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) r_rr[w_index] <= (r_rr[w_index] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_index] + WAY_W'(1);
      end
      if (w_write_ack)          r_wr_done <= 1'b1;
      else if (w_idle && !flush) r_wr_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_sa.sv
// tb/tb_cache_sa.sv - directed self-checking bench for cache_sa with a word-serial memory responder
module tb_cache_sa;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_write, flush, mem_ack;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [3:0]  req_be;
  logic [31:0] rdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          stalls;
  logic [31:0] rd;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ack_addr_q [$];
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  cache_sa #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(8), .WAYS(2), .BLOCK_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .flush(flush),
    .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hD000_0000 | a);
  endfunction

  initial begin
    int          wait_cnt;
    logic [31:0] merged;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          ack_addr_q.push_back(mem_addr);
          last_we    = mem_we;
          last_be    = mem_be;
          last_wdata = mem_wdata;
          if (mem_we) begin
            merged = mem_read(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = merged;
          end else begin
            mem_rdata = mem_read(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (stall) check("stall_timeout", {31'b0, stall}, 32'h0);
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int dly, output int n, output logic [31:0] r);
    @(negedge clk);
    ack_delay = dly;
    ack_addr_q.delete();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    #1;
    wait_stall(n);
    r = rdata;
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; flush = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < 4; i++) mem[32'h100 + 4*i] = 32'hA0 + i;
    do_reset();
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);

    access(1'b0, 32'h100, '0, 4'h0, 0, stalls, rd);
    check("miss100_stalls", stalls, 5);
    check("miss100_rdata", rd, 32'hA0);
    check("miss100_nacks", ack_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) check("miss100_addr", (ack_addr_q.size() > i) ? ack_addr_q[i] : 32'hX, 32'h100 + 4*i);
    check("miss100_misses", miss_count, 32'd1);
    access(1'b0, 32'h108, '0, 4'h0, 0, stalls, rd);
    check("hit108_stalls", stalls, 0);
    check("hit108_rdata", rd, 32'hA2);
    check("hit108_hits", hit_count, 32'd1);
    go_idle();
    check("idle_rdata", rdata, 32'h0);
    check("s1_hits", hit_count, 32'd2);

    access(1'b1, 32'h108, 32'h1234_5678, 4'b0011, 1, stalls, rd);
    check("st108_stalls", stalls, 3);
    check("st108_we", {31'b0, last_we}, 32'h1);
    check("st108_be", {28'b0, last_be}, 32'h3);
    check("st108_wdata", last_wdata, 32'h1234_5678);
    check("st108_addr", (ack_addr_q.size() > 0) ? ack_addr_q[0] : 32'hX, 32'h108);
    access(1'b0, 32'h108, '0, 4'h0, 0, stalls, rd);
    check("ld108_stalls", stalls, 0);
    check("ld108_merge", rd, 32'h0000_5678);
    access(1'b1, 32'h900, 32'hCAFE_F00D, 4'hF, 0, stalls, rd);
    check("st900_stalls", stalls, 2);
    access(1'b0, 32'h900, '0, 4'h0, 0, stalls, rd);
    check("ld900_stalls", stalls, 5);
    check("ld900_rdata", rd, 32'hCAFE_F00D);
    go_idle();
    check("s2_misses", miss_count, 32'd2);
    check("s2_hits", hit_count, 32'd4);

    do_reset();
    access(1'b0, 32'h000, '0, 4'h0, 0, stalls, rd);
    check("ld000_stalls", stalls, 5);
    check("ld000_rdata", rd, 32'hD000_0000);
    access(1'b0, 32'h080, '0, 4'h0, 0, stalls, rd);
    check("ld080_stalls", stalls, 5);
    access(1'b0, 32'h100, '0, 4'h0, 0, stalls, rd);
    check("ld100_stalls", stalls, 5);
    check("ld100_rdata", rd, 32'hA0);
    access(1'b0, 32'h080, '0, 4'h0, 0, stalls, rd);
    check("re080_hit_stalls", stalls, 0);
    check("re080_rdata", rd, 32'hD000_0080);
    access(1'b0, 32'h000, '0, 4'h0, 0, stalls, rd);
    check("re000_evicted", stalls, 5);
    go_idle();
    check("s3_misses", miss_count, 32'd4);
    check("s3_hits", hit_count, 32'd5);

    do_reset();
    @(negedge clk);
    ack_delay = 0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_mem_req", {31'b0, mem_req}, 32'h0);
    check("rstmid_misses", miss_count, 32'h0);
    check("rstmid_hits", hit_count, 32'h0);
    check("rstmid_line_invalid", {31'b0, stall}, 32'h1);
    wait_stall(stalls);
    check("rstmid_refill_stalls", stalls, 5);
    check("rstmid_rdata", rdata, 32'hD000_0200);
    go_idle();
    check("rstmid_misses_after", miss_count, 32'd1);

    do_reset();
    access(1'b0, 32'h000, '0, 4'h0, 0, stalls, rd);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall}, 32'h1);
    check("flush_rdata", rdata, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("postflush_stall", {31'b0, stall}, 32'h1);
    check("postflush_hits", hit_count, 32'd1);
    check("postflush_misses", miss_count, 32'd1);
    wait_stall(stalls);
    check("postflush_stalls", stalls, 5);
    go_idle();
    check("s5_misses", miss_count, 32'd2);

    @(negedge clk);
    force dut.r_hit_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_hit_count;
    #1;
    check("sat_preload", hit_count, 32'hFFFF_FFFE);
    access(1'b0, 32'h000, '0, 4'h0, 0, stalls, rd);
    go_idle();
    check("sat_first", hit_count, 32'hFFFF_FFFF);
    access(1'b0, 32'h000, '0, 4'h0, 0, stalls, rd);
    go_idle();
    check("sat_hold", hit_count, 32'hFFFF_FFFF);
    check("sat_misses", miss_count, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
